// File: rtl/register_write_scheduler.sv
// Queues register-write commands from the SPI slave and releases them to parameter
// storage only inside a write window that opens on each sample-frame boundary.
module register_write_scheduler #(
  parameter int DEPTH         = 4,
  parameter int WINDOW_CYCLES = 16
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     i_RegisterWriteEnable,
  input  logic [15:0]              i_RegisterWriteNumber,
  input  logic [15:0]              i_RegisterWriteValue,
  input  logic                     i_SampleReady,
  output logic                     o_WriteEnable,
  output logic [1:0]               o_WriteTarget,
  output logic [7:0]               o_WriteAddress,
  output logic [15:0]              o_WriteValue,
  output logic [$clog2(DEPTH):0]   o_QueueCount,
  output logic                     o_Overflow,
  output logic                     o_BadTarget,
  output logic                     o_WindowOpen
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, WINDOW} state_t;

  // Entry layout: {target[1:0], address[7:0], value[15:0]}
  logic [25:0]   mem [DEPTH];

  state_t        state_q, state_d;
  logic [7:0]    win_cnt_q, win_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          prev_en_q, prev_en_d;
  logic          we_q, we_d;
  logic [1:0]    tgt_q, tgt_d;
  logic [7:0]    addr_q, addr_d;
  logic [15:0]   val_q, val_d;
  logic          ovf_q, ovf_d;
  logic          bad_q, bad_d;
  logic          win_open_q, win_open_d;

  logic          detect;
  logic          target_ok;
  logic          push_ok;
  logic          pop;
  logic [25:0]   rd_entry;
  logic [25:0]   wr_entry;

  assign detect    = i_RegisterWriteEnable & ~prev_en_q;
  assign target_ok = (i_RegisterWriteNumber[15:8] <= 8'h02);
  assign pop       = (state_q == WINDOW) && (count_q != '0);
  // A full queue still accepts when the same cycle frees a slot.
  assign push_ok   = detect && target_ok && ((count_q < CW'(DEPTH)) || pop);
  assign wr_entry  = {i_RegisterWriteNumber[9:8], i_RegisterWriteNumber[7:0], i_RegisterWriteValue};
  assign rd_entry  = mem[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    prev_en_d  = i_RegisterWriteEnable;
    we_d       = pop;
    tgt_d      = tgt_q;
    addr_d     = addr_q;
    val_d      = val_q;
    ovf_d      = ovf_q;
    bad_d      = bad_q;

    if (detect && !target_ok) bad_d = 1'b1;
    if (detect && target_ok && !push_ok) ovf_d = 1'b1;

    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      tgt_d    = rd_entry[25:24];
      addr_d   = rd_entry[23:16];
      val_d    = rd_entry[15:0];
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (i_SampleReady) begin
          state_d   = WINDOW;
          win_cnt_d = 8'(WINDOW_CYCLES - 1);
        end
      end
      WINDOW: begin
        if (i_SampleReady) begin
          win_cnt_d = 8'(WINDOW_CYCLES - 1);
        end else if (win_cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          win_cnt_d = win_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    win_open_d = (state_d == WINDOW);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      win_cnt_q  <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      prev_en_q  <= 1'b1;  // an enable held through reset must not look like a new edge
      we_q       <= 1'b0;
      tgt_q      <= 2'd0;
      addr_q     <= 8'd0;
      val_q      <= 16'd0;
      ovf_q      <= 1'b0;
      bad_q      <= 1'b0;
      win_open_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      prev_en_q  <= prev_en_d;
      we_q       <= we_d;
      tgt_q      <= tgt_d;
      addr_q     <= addr_d;
      val_q      <= val_d;
      ovf_q      <= ovf_d;
      bad_q      <= bad_d;
      win_open_q <= win_open_d;
    end
  end

  // Storage has no reset; resetting the pointers and count discards the contents.
  always_ff @(posedge i_Clock) begin
    if (push_ok && !i_Reset) mem[wr_ptr_q] <= wr_entry;
  end

  assign o_WriteEnable  = we_q;
  assign o_WriteTarget  = tgt_q;
  assign o_WriteAddress = addr_q;
  assign o_WriteValue   = val_q;
  assign o_QueueCount   = count_q;
  assign o_Overflow     = ovf_q;
  assign o_BadTarget    = bad_q;
  assign o_WindowOpen   = win_open_q;

endmodule

// File: tb/tb_register_write_scheduler.sv
// Directed bench: a queue-based model checked every cycle, plus literal checks on
// the captured write stream for the ordered-drain, overflow, level and window scenarios.
module tb_register_write_scheduler;

  localparam int DEPTH = 4;
  localparam int WIN   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] num = 16'd0;
  logic [15:0] val = 16'd0;
  logic        sr = 1'b0;
  logic        o_we;
  logic [1:0]  o_tgt;
  logic [7:0]  o_addr;
  logic [15:0] o_val;
  logic [2:0]  o_cnt;
  logic        o_ovf;
  logic        o_bad;
  logic        o_win;

  register_write_scheduler #(.DEPTH(DEPTH), .WINDOW_CYCLES(WIN)) dut (
    .i_Clock              (clk),
    .i_Reset              (rst),
    .i_RegisterWriteEnable(en),
    .i_RegisterWriteNumber(num),
    .i_RegisterWriteValue (val),
    .i_SampleReady        (sr),
    .o_WriteEnable        (o_we),
    .o_WriteTarget        (o_tgt),
    .o_WriteAddress       (o_addr),
    .o_WriteValue         (o_val),
    .o_QueueCount         (o_cnt),
    .o_Overflow           (o_ovf),
    .o_BadTarget          (o_bad),
    .o_WindowOpen         (o_win)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a plain queue plus "cycles of window left" (0 = closed).
  logic [25:0] mq[$];
  int          m_left = 0;
  bit          m_prev = 1'b1;
  bit          m_we = 1'b0;
  logic [25:0] m_out = '0;
  bit          m_ovf = 1'b0;
  bit          m_bad = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_left = 0; m_prev = 1'b1; m_we = 1'b0; m_out = '0; m_ovf = 1'b0; m_bad = 1'b0;
    end else begin
      bit det;
      det = en && !m_prev;
      m_prev = en;
      m_we = (m_left > 0) && (mq.size() > 0);
      if (m_we) m_out = mq.pop_front();
      if (det) begin
        if (num[15:8] > 8'd2) m_bad = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back({num[9:8], num[7:0], val});
        else m_ovf = 1'b1;
      end
      if (sr) m_left = WIN;
      else if (m_left > 0) m_left--;
    end
  end

  logic [25:0] wlog[$];
  int          win_cycles = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("write_enable", o_we, m_we);
      check("write_fields", {o_tgt, o_addr, o_val}, m_out);
      check("queue_count", o_cnt, mq.size());
      check("overflow", o_ovf, m_ovf);
      check("bad_target", o_bad, m_bad);
      check("window_open", o_win, m_left > 0);
    end
    if (o_we) wlog.push_back({o_tgt, o_addr, o_val});
    if (o_win) win_cycles++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick();
    rst = 1'b0; tick();
  endtask

  task automatic send(input logic [15:0] n, input logic [15:0] v);
    en = 1'b1; num = n; val = v; tick();
    en = 1'b0; tick();
    $display("[TB] cmd number=0x%04h value=0x%04h count=%0d", n, v, o_cnt);
  endtask

  task automatic pulse_sr();
    sr = 1'b1; tick();
    sr = 1'b0;
  endtask

  task automatic drain();
    pulse_sr();
    repeat (WIN + 8) tick();
  endtask

  initial begin
    logic [25:0] exp_e [5];
    tick();
    chk_en = 1'b1;
    rst = 1'b1; tick();
    check("reset_count", o_cnt, 0);
    check("reset_we", o_we, 0);
    check("reset_window", o_win, 0);
    check("reset_flags", {o_ovf, o_bad}, 0);
    rst = 1'b0; tick();

    // Ordered drain
    wlog.delete();
    send(16'h0105, 16'hABCD);
    send(16'h0007, 16'h1234);
    check("drain_count_before", o_cnt, 2);
    drain();
    check("drain_n", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("drain_0", wlog[0], {2'd1, 8'h05, 16'hABCD});
      check("drain_1", wlog[1], {2'd0, 8'h07, 16'h1234});
    end
    check("drain_count_after", o_cnt, 0);
    $display("[TB] ordered drain: %0d writes", wlog.size());

    // Full queue accepts a push that coincides with a pop
    do_reset();
    wlog.delete();
    for (int i = 0; i < 4; i++) send(16'h0010 + 16'(i), 16'h1000 + 16'(i));
    pulse_sr();
    en = 1'b1; num = 16'h0209; val = 16'h9999; tick();
    en = 1'b0;
    check("fullpop_count", o_cnt, 4);
    check("fullpop_ovf", o_ovf, 0);
    repeat (WIN + 8) tick();
    check("fullpop_n", wlog.size(), 5);
    if (wlog.size() == 5) check("fullpop_last", wlog[4], {2'd2, 8'h09, 16'h9999});
    $display("[TB] full+pop: %0d writes", wlog.size());

    // Overflow
    do_reset();
    wlog.delete();
    for (int i = 0; i < 5; i++) begin
      exp_e[i] = {2'(i % 3), 8'h20 + 8'(i), 16'hC000 + 16'(i)};
      send({8'(i % 3), 8'h20 + 8'(i)}, 16'hC000 + 16'(i));
    end
    check("ovf_count", o_cnt, 4);
    check("ovf_flag", o_ovf, 1);
    drain();
    check("ovf_n", wlog.size(), 4);
    if (wlog.size() == 4)
      for (int i = 0; i < 4; i++) check("ovf_entry", wlog[i], exp_e[i]);
    $display("[TB] overflow: %0d writes", wlog.size());

    // Bad target
    send(16'h0312, 16'h4444);
    check("bad_flag", o_bad, 1);
    check("bad_count", o_cnt, 0);

    // Level held high
    en = 1'b1; num = 16'h0201; val = 16'h5555;
    repeat (40) tick();
    en = 1'b0; tick();
    check("level_count", o_cnt, 1);
    $display("[TB] level held: count=%0d", o_cnt);
    drain();

    // Window timing with a mid-window extension
    win_cycles = 0;
    pulse_sr();
    repeat (9) tick();
    pulse_sr();
    repeat (WIN + 8) tick();
    check("window_cycles", win_cycles, 10 + WIN);
    $display("[TB] window open cycles=%0d", win_cycles);

    // Reset mid-window
    do_reset();
    for (int i = 0; i < 3; i++) send(16'h0130 + 16'(i), 16'h7000 + 16'(i));
    wlog.delete();
    pulse_sr();
    check("midrst_open", o_win, 1);
    rst = 1'b1; tick();
    rst = 1'b0;
    check("midrst_count", o_cnt, 0);
    check("midrst_window", o_win, 0);
    repeat (WIN + 8) tick();
    check("midrst_writes", wlog.size(), 0);
    $display("[TB] reset mid-window: %0d writes after reset", wlog.size());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
